// File: rtl/cpu_sequencer_32bit.sv
// Multi-cycle control sequencer for a small RISC-V integer core (R/I ALU, beq/bne, ecall).
// Latency: ALU op FETCH->WRITEBACK 4 cycles, branch 3, with mem_ready high on the first FETCH cycle.
// Backpressure: FETCH stalls while mem_ready is low; halts on fetch timeout. Macro: CPU_SEQUENCER_ILLEGAL_TRAP_EN.
module cpu_sequencer_32bit #(
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] instruction,
    input  logic        alu_zero,
    output logic        ir_load,
    output logic        pc_write_enable,
    output logic        pc_src_branch,
    output logic        rf_write_enable,
    output logic [2:0]  alu_f3,
    output logic        alu_f9,
    output logic        alu_src_imm,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam int unsigned WAIT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = FETCH_TIMEOUT[WAIT_W-1:0];

`ifdef CPU_SEQUENCER_ILLEGAL_TRAP_EN
    localparam bit ILLEGAL_TRAP = 1'b1;
`else
    localparam bit ILLEGAL_TRAP = 1'b0;
`endif

    state_t            cur_state;
    state_t            nxt_state;
    logic [31:0]       ir;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              timeout_hit;

    // Decode fields always come from the latched IR, never the live bus.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       is_r;
    logic       is_i;
    logic       is_br;
    logic       is_ecall;
    logic       is_ill;
    logic       illegal_nop;
    logic       retire_now;
    logic       unused_ir_bits;

    assign opcode         = ir[6:0];
    assign funct3         = ir[14:12];
    assign rd             = ir[11:7];
    assign is_r           = (opcode == 7'b0110011);
    assign is_i           = (opcode == 7'b0010011);
    assign is_br          = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
    assign is_ecall       = (opcode == 7'b1110011);
    assign is_ill         = !(is_r || is_i || is_br || is_ecall);
    assign illegal_nop    = (cur_state == S_DECODE) && is_ill && !ILLEGAL_TRAP;
    assign unused_ir_bits = ^{ir[31], ir[29:15]};

    // The wait counter counts stalled FETCH cycles; the cycle that makes it reach the limit halts.
    assign wait_inc    = wait_cnt + 1'b1;
    assign timeout_hit = !mem_ready && (wait_inc == TIMEOUT_VAL);

    // An instruction retires in WRITEBACK, in a branch EXECUTE, or as an untrapped illegal NOP.
    assign retire_now = (cur_state == S_WRITEBACK)
                     || ((cur_state == S_EXECUTE) && is_br)
                     || illegal_nop;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state selection.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:      if (run) nxt_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        nxt_state = S_DECODE;
                else if (timeout_hit) nxt_state = S_HALT;
            end
            S_DECODE: begin
                if (is_ecall)    nxt_state = S_HALT;
                else if (is_ill) nxt_state = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                else             nxt_state = S_EXECUTE;
            end
            S_EXECUTE:   nxt_state = is_br ? S_FETCH : S_WRITEBACK;
            S_WRITEBACK: nxt_state = run ? S_FETCH : S_IDLE;
            S_HALT:      nxt_state = S_HALT;
            default:     nxt_state = S_IDLE;
        endcase
    end

    // Strobes and ALU controls; ALU fields are recomputed from IR so WRITEBACK holds the EXECUTE values.
    always_comb begin
        ir_load         = 1'b0;
        pc_write_enable = 1'b0;
        pc_src_branch   = 1'b0;
        rf_write_enable = 1'b0;
        alu_f3          = 3'b000;
        alu_f9          = 1'b0;
        alu_src_imm     = 1'b0;
        case (cur_state)
            S_FETCH:  ir_load = mem_ready;
            S_DECODE: pc_write_enable = illegal_nop;
            S_EXECUTE, S_WRITEBACK: begin
                if (is_br) begin
                    alu_f9 = 1'b1;
                end else if (is_r) begin
                    alu_f3 = funct3;
                    alu_f9 = ir[30];
                end else if (is_i) begin
                    alu_f3      = funct3;
                    alu_f9      = (funct3 == 3'b101) ? ir[30] : 1'b0;
                    alu_src_imm = 1'b1;
                end
                if (cur_state == S_EXECUTE) begin
                    pc_write_enable = is_br;
                    pc_src_branch   = is_br && (funct3[0] ? !alu_zero : alu_zero);
                end else begin
                    pc_write_enable = 1'b1;
                    rf_write_enable = (rd != 5'd0);
                end
            end
            default: ;
        endcase
    end

    // IR, fetch wait counter, retire counter and halt cause.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir       <= 32'd0;
            wait_cnt <= '0;
            retired  <= 32'd0;
            fault    <= 2'b00;
        end else begin
            if (ir_load) ir <= instruction;
            if (cur_state == S_FETCH) begin
                wait_cnt <= mem_ready ? '0 : wait_inc;
                if (timeout_hit) fault <= 2'b10;
            end
            if (cur_state == S_DECODE) begin
                if (is_ecall)                  fault <= 2'b00;
                else if (is_ill && ILLEGAL_TRAP) fault <= 2'b01;
            end
            if (retire_now) retired <= retired + 32'd1;
        end
    end

    assign state  = cur_state;
    assign halted = (cur_state == S_HALT);

endmodule
